pixel_sink: RTL
===============

Name: pixel_sink

Overview:
- Consumer end of the pixel-write interface driven by the draw FSMs (hook, rope, miners, objects): x, y, 12-bit colour and write-enable.
- Clips each pixel to the 320x240 screen and buffers it in a small FIFO.
- Converts it to a linear framebuffer address and issues one framebuffer RAM write per cycle.
- Owns a screen-clear sequencer that floods the framebuffer with a background colour. Incoming pixels are held in the FIFO while a clear runs.

Parameters:
- SCREEN_W, 320, visible width in pixels.
- SCREEN_H, 240, visible height in pixels.
- FIFO_DEPTH, 16, pixel FIFO entries (power of two).
- ADDR_W, 17, framebuffer address width (SCREEN_W*SCREEN_H <= 2^ADDR_W).

Ports:
- clock  in  1  system clock, all logic on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- pix_x  in  9  pixel X from the drawer.
- pix_y  in  8  pixel Y from the drawer.
- pix_color  in  12  pixel colour, RGB 4:4:4.
- pix_we  in  1  pixel valid; sampled every rising edge; no backpressure.
- clear_req  in  1  request a full-screen clear; sampled every edge.
- clear_color  in  12  background colour; latched when clear_req is accepted.
- fb_addr  out  ADDR_W  framebuffer write address (registered).
- fb_data  out  12  framebuffer write data (registered).
- fb_we  out  1  framebuffer write strobe (registered).
- clear_busy  out  1  high while in S_CLEAR.
- clear_done  out  1  one-cycle pulse after the last clear write.
- clipped  out  1  one-cycle pulse when an input pixel was discarded off-screen.
- overflow  out  1  sticky: a pixel was dropped because the FIFO was full.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (asynchronous, resetn=0):
  - state = S_IDLE; FIFO empty.
  - fb_addr, fb_data, fb_we, clear_busy, clear_done, clipped and overflow all 0; fifo_level = 0.
  - Reset mid-clear abandons the clear with no clear_done; reset mid-drain discards queued pixels.
- Input stage, every edge with pix_we=1:
  - If pix_x >= SCREEN_W or pix_y >= SCREEN_H, the pixel is dropped and clipped pulses high the next cycle.
  - Otherwise push {pix_x, pix_y, pix_color} into the FIFO.
- FIFO push/pop rules:
  - Push when full with no pop in the same cycle: pixel dropped, overflow set to 1.
  - Push and pop in the same cycle when full: both succeed, level unchanged.
  - Pop when empty: never happens.
  - overflow clears only on reset or on an accepted clear_req.
- Address arithmetic:
  - fb_addr = y*SCREEN_W + x, computed unsigned at ADDR_W bits.
  - For 320: (y<<8) + (y<<6) + x. No multiplier is required; a multiplier is allowed if timing meets.
  - Maximum value is 76799.
- State S_IDLE (drain):
  - If the FIFO is non-empty, pop the head. Register fb_addr from the popped x/y, fb_data = colour, fb_we = 1 at the next edge. Otherwise fb_we = 0.
  - Latency: pix_we sampled at edge k into an empty FIFO gives fb_we=1 during cycle k+1..k+2. Throughput is 1 pixel per cycle.
  - clear_req=1 moves to S_CLEAR at the next edge: latch clear_color, counter = 0, clear_busy = 1, overflow = 0.
  - clear_req has priority over the drain: the FIFO head is not popped in that cycle.
- State S_CLEAR:
  - Each cycle: fb_addr = counter, fb_data = latched colour, fb_we = 1; then counter increments.
  - After the write at counter = SCREEN_W*SCREEN_H-1 (76799):
    - return to S_IDLE;
    - clear_busy = 0;
    - clear_done = 1 for exactly one cycle, the cycle after the last write.
  - Exactly 76800 fb_we cycles per clear.
  - clear_req during S_CLEAR is ignored (no restart, no queuing).
  - Pixel pushes continue during S_CLEAR and no pops occur. Queued pixels drain in S_IDLE afterwards, so drawn pixels overwrite the background.
- Writes from the clear and from the drain are never issued in the same cycle; there is one RAM write port.
- clipped and clear_done are pulses, deasserted every cycle unless re-triggered.
- fifo_level reflects occupancy after the current edge's push and pop.

Test Plan:
- Reset, then pix_we=1 for one cycle with x=160, y=45, colour=0xBBB -> one cycle later fb_we=1, fb_addr=14560, fb_data=0xBBB, then fb_we=0; fifo_level returns to 0.
- 20 consecutive in-range pixels in S_IDLE -> 20 consecutive fb_we cycles in input order, overflow stays 0, fifo_level never exceeds 1.
- pix_x=320,y=10 and pix_x=5,y=240 -> no fb_we, clipped pulses once per pixel; pix_x=319,y=239 -> fb_addr=76799.
- clear_req with clear_color=0x000 -> clear_busy high for 76800 cycles with fb_addr 0..76799 and fb_data=0x000; clear_done pulses once; a second clear_req mid-clear is ignored.
- 20 pixels pushed during a clear with FIFO_DEPTH=16 -> overflow=1 after the 17th pixel; after clear_done, exactly 16 fb_we drain writes carry the first 16 pixels; the next clear_req clears overflow.
- Assert resetn=0 mid-clear at counter 1000 -> all outputs 0 immediately (asynchronously), no clear_done; after release, the next pixel writes normally.

Source files
------------

// File: rtl/pixel_sink.sv
// ============================================================================
//  Module   : pixel_sink
//  Purpose  : Clips drawer pixels to the screen, queues them in a FIFO and
//             writes them to the framebuffer; also floods the screen on clear.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pixel_sink #(
    parameter int SCREEN_W   = 320,
    parameter int SCREEN_H   = 240,
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_W     = 17
) (
    input  logic                          clock,
    input  logic                          resetn,
    input  logic [8:0]                    pix_x,
    input  logic [7:0]                    pix_y,
    input  logic [11:0]                   pix_color,
    input  logic                          pix_we,
    input  logic                          clear_req,
    input  logic [11:0]                   clear_color,
    output logic [ADDR_W-1:0]             fb_addr,
    output logic [11:0]                   fb_data,
    output logic                          fb_we,
    output logic                          clear_busy,
    output logic                          clear_done,
    output logic                          clipped,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int c_PTR_W   = $clog2(FIFO_DEPTH);
    localparam int c_LVL_W   = c_PTR_W + 1;
    localparam int c_ENTRY_W = 9 + 8 + 12;

    localparam logic [8:0]        c_W_LIM = 9'(SCREEN_W);
    localparam logic [7:0]        c_H_LIM = 8'(SCREEN_H);
    localparam logic [ADDR_W-1:0] c_LAST  = ADDR_W'(SCREEN_W * SCREEN_H - 1);
    localparam logic [c_LVL_W-1:0] c_FULL = c_LVL_W'(FIFO_DEPTH);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t                 r_state;
    logic [ADDR_W-1:0]      r_cnt;
    logic [11:0]            r_clear_color;
    logic [c_ENTRY_W-1:0]   r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]     r_wr_ptr;
    logic [c_PTR_W-1:0]     r_rd_ptr;
    logic [c_LVL_W-1:0]     r_level;

    logic                   w_in_range;
    logic                   w_push_req;
    logic                   w_full;
    logic                   w_pop;
    logic                   w_push_ok;
    logic                   w_drop;
    logic                   w_clear_accept;
    logic [c_ENTRY_W-1:0]   w_head;
    logic [ADDR_W-1:0]      w_head_x;
    logic [ADDR_W-1:0]      w_head_y;
    logic [ADDR_W-1:0]      w_pix_addr;

    assign w_in_range     = (pix_x < c_W_LIM) && (pix_y < c_H_LIM);
    assign w_push_req     = pix_we && w_in_range;
    assign w_full         = (r_level == c_FULL);
    assign w_clear_accept = (r_state == S_IDLE) && clear_req;
    // A clear request wins over the drain, so the head stays put that cycle.
    assign w_pop          = (r_state == S_IDLE) && !clear_req && (r_level != '0);
    assign w_push_ok      = w_push_req && (!w_full || w_pop);
    assign w_drop         = w_push_req && w_full && !w_pop;

    assign w_head   = r_mem[r_rd_ptr];
    assign w_head_x = ADDR_W'(w_head[28:20]);
    assign w_head_y = ADDR_W'(w_head[19:12]);

    generate
        if (SCREEN_W == 320) begin : g_addr_shift
            assign w_pix_addr = (w_head_y << 8) + (w_head_y << 6) + w_head_x;
        end else begin : g_addr_mul
            assign w_pix_addr = w_head_y * ADDR_W'(SCREEN_W) + w_head_x;
        end
    endgenerate

    assign fifo_level = r_level;

    // Storage needs no reset; occupancy is tracked by the pointers and level.
    always_ff @(posedge clock) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= {pix_x, pix_y, pix_color};
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_clear_color <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_level       <= '0;
            fb_addr       <= '0;
            fb_data       <= '0;
            fb_we         <= 1'b0;
            clear_busy    <= 1'b0;
            clear_done    <= 1'b0;
            clipped       <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            clipped    <= pix_we && !w_in_range;
            clear_done <= 1'b0;
            fb_we      <= 1'b0;
            overflow   <= (overflow && !w_clear_accept) || w_drop;

            unique case (r_state)
                S_IDLE: begin
                    if (clear_req) begin
                        r_state       <= S_CLEAR;
                        r_clear_color <= clear_color;
                        r_cnt         <= '0;
                        clear_busy    <= 1'b1;
                    end else if (r_level != '0) begin
                        fb_we   <= 1'b1;
                        fb_addr <= w_pix_addr;
                        fb_data <= w_head[11:0];
                    end
                end
                S_CLEAR: begin
                    fb_we   <= 1'b1;
                    fb_addr <= r_cnt;
                    fb_data <= r_clear_color;
                    if (r_cnt == c_LAST) begin
                        r_state    <= S_IDLE;
                        clear_busy <= 1'b0;
                        clear_done <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + ADDR_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_push_ok) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            if (w_pop)     r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);

            unique case ({w_push_ok, w_pop})
                2'b10:   r_level <= r_level + c_LVL_W'(1);
                2'b01:   r_level <= r_level - c_LVL_W'(1);
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire
